// File: rtl/rr_lock_arbiter_pkg.sv
// Shared constants and width helpers for the round-robin lock arbiter.
package arb_pkg;

  localparam int MAX_CH = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width never collapses to zero, even for a single channel.
  function automatic int chosen_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Handshake bundle between N producers, the arbiter and one shared consumer.
interface rr_lock_arbiter_if
  import arb_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8
);
  localparam int CHOSEN_W = chosen_w(N_INPUTS);

  logic [N_INPUTS-1:0]        io_in_valid;
  logic [N_INPUTS-1:0]        io_in_ready;
  logic [N_INPUTS*DATA_W-1:0] io_in_bits;
  logic [N_INPUTS-1:0]        io_in_last;
  logic                       io_out_ready;
  logic                       io_out_valid;
  logic [DATA_W-1:0]          io_out_bits;
  logic                       io_out_last;
  logic [CHOSEN_W-1:0]        io_out_chosen;

  modport master (
    output io_in_valid, io_in_bits, io_in_last, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_out_last, io_out_chosen
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_in_last, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_out_last, io_out_chosen
  );

endinterface

// File: rtl/rr_lock_arbiter_pick.sv
// Rotating-priority picker: first set req bit strictly after ptr, wrapping at N-1.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  logic [W-1:0]   start;
  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;

  always_comb begin
    // Explicit wrap so non power-of-two N never lands on a phantom index.
    start = (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
    for (int i = 0; i < N; i++) mask[i] = (W'(i) >= start);
    dbl = {req, req & mask};

    any       = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!any && dbl[i]) begin
        any       = 1'b1;
        grant_idx = (i >= N) ? W'(i - N) : W'(i);
      end
    end

    for (int j = 0; j < N; j++) grant_onehot[j] = any && (grant_idx == W'(j));
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-input round-robin arbiter with burst locking on !last and a registered output stage.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  rr_lock_arbiter_if.slave  io
);

  localparam int CHOSEN_W = chosen_w(N_INPUTS);

  logic [CHOSEN_W-1:0] ptr;
  logic                locked;
  logic [CHOSEN_W-1:0] lock_ch;

  logic                out_valid;
  logic [DATA_W-1:0]   out_bits;
  logic                out_last;
  logic [CHOSEN_W-1:0] out_chosen;

  logic [N_INPUTS-1:0] lock_mask;
  logic [N_INPUTS-1:0] req;
  logic [N_INPUTS-1:0] grant_onehot;
  logic [CHOSEN_W-1:0] grant_idx;
  logic                grant_any;
  logic                can_take;
  logic                accept;
  logic [DATA_W-1:0]   sel_bits;
  logic                sel_last;

  // While locked only the lock owner may compete, so the picker sees at most one request.
  always_comb begin
    for (int j = 0; j < N_INPUTS; j++) lock_mask[j] = (lock_ch == CHOSEN_W'(j));
    req = locked ? (io.io_in_valid & lock_mask) : io.io_in_valid;
  end

  rr_priority_pick #(
    .N (N_INPUTS),
    .W (CHOSEN_W)
  ) u_pick (
    .req          (req),
    .ptr          (ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  assign can_take       = !out_valid || io.io_out_ready;
  assign accept         = grant_any && can_take;
  assign io.io_in_ready = grant_onehot & {N_INPUTS{can_take}};

  always_comb begin
    sel_bits = '0;
    sel_last = 1'b0;
    for (int j = 0; j < N_INPUTS; j++) begin
      if (grant_onehot[j]) begin
        sel_bits = io.io_in_bits[j*DATA_W +: DATA_W];
        sel_last = io.io_in_last[j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= CHOSEN_W'(N_INPUTS - 1);
      locked     <= 1'b0;
      lock_ch    <= '0;
      out_valid  <= 1'b0;
      out_bits   <= '0;
      out_last   <= 1'b0;
      out_chosen <= '0;
    end else if (accept) begin
      ptr        <= grant_idx;
      locked     <= !sel_last;
      if (!sel_last) lock_ch <= grant_idx;
      out_valid  <= 1'b1;
      out_bits   <= sel_bits;
      out_last   <= sel_last;
      out_chosen <= grant_idx;
    end else if (io.io_out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign io.io_out_valid  = out_valid;
  assign io.io_out_bits   = out_bits;
  assign io.io_out_last   = out_last;
  assign io.io_out_chosen = out_chosen;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: a 4-input and a 3-input instance share clock and reset.
module tb_rr_lock_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rr_lock_arbiter_if #(.N_INPUTS(4), .DATA_W(8)) ifa ();
  rr_lock_arbiter_if #(.N_INPUTS(3), .DATA_W(8)) ifb ();

  rr_lock_arbiter #(.N_INPUTS(4), .DATA_W(8)) dut_a (.clk(clk), .reset(reset), .io(ifa));
  rr_lock_arbiter #(.N_INPUTS(3), .DATA_W(8)) dut_b (.clk(clk), .reset(reset), .io(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.io_in_valid  = '0;
    ifa.io_in_bits   = '0;
    ifa.io_in_last   = '0;
    ifa.io_out_ready = 1'b1;
    ifb.io_in_valid  = '0;
    ifb.io_in_bits   = '0;
    ifb.io_in_last   = '0;
    ifb.io_out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst_valid", 32'(ifa.io_out_valid), 32'h0);
    chk("rst_bits", 32'(ifa.io_out_bits), 32'h0);
    chk("rst_last", 32'(ifa.io_out_last), 32'h0);
    chk("rst_chosen", 32'(ifa.io_out_chosen), 32'h0);
    chk("rst_in_ready", 32'(ifa.io_in_ready), 32'h0);
    reset = 1'b0;

    // 1: async reset mid-traffic, then first grant goes to ch0
    ifa.io_in_valid = 4'b1111;
    ifa.io_in_bits  = {8'h13, 8'h12, 8'h11, 8'h10};
    ifa.io_in_last  = 4'b1111;
    tick();
    chk("t1_pre_valid", 32'(ifa.io_out_valid), 32'h1);
    chk("t1_pre_bits", 32'(ifa.io_out_bits), 32'h10);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_valid", 32'(ifa.io_out_valid), 32'h0);
    chk("t1_async_bits", 32'(ifa.io_out_bits), 32'h0);
    chk("t1_async_chosen", 32'(ifa.io_out_chosen), 32'h0);
    tick();
    reset = 1'b0;
    ifa.io_in_valid = 4'b0101;
    ifa.io_in_bits  = {8'h00, 8'hA2, 8'h00, 8'hA0};
    ifa.io_in_last  = 4'b1111;
    #4;
    chk("t1_ready0", 32'(ifa.io_in_ready), 32'h1);
    tick();
    chk("t1_chosen0", 32'(ifa.io_out_chosen), 32'h0);
    chk("t1_bits0", 32'(ifa.io_out_bits), 32'hA0);
    chk("t1_ready2", 32'(ifa.io_in_ready), 32'h4);
    tick();
    chk("t1_chosen2", 32'(ifa.io_out_chosen), 32'h2);
    chk("t1_bits2", 32'(ifa.io_out_bits), 32'hA2);

    // 2: full rotation 0,1,2,3,0
    do_reset();
    ifa.io_in_valid = 4'b1111;
    ifa.io_in_bits  = {8'h13, 8'h12, 8'h11, 8'h10};
    ifa.io_in_last  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_valid", 32'(ifa.io_out_valid), 32'h1);
      chk("t2_chosen", 32'(ifa.io_out_chosen), 32'(k % 4));
      chk("t2_bits", 32'(ifa.io_out_bits), 32'(8'h10 + k % 4));
    end

    // 3: ch1 three-beat burst locks out ch0/ch2
    do_reset();
    ifa.io_in_valid = 4'b0001;
    ifa.io_in_bits  = {8'h00, 8'h00, 8'h00, 8'h20};
    ifa.io_in_last  = 4'b1111;
    tick();
    chk("t3_prime", 32'(ifa.io_out_chosen), 32'h0);
    ifa.io_in_valid = 4'b0111;
    ifa.io_in_bits  = {8'h00, 8'h22, 8'h31, 8'h20};
    ifa.io_in_last  = 4'b1101;
    tick();
    chk("t3_b1_chosen", 32'(ifa.io_out_chosen), 32'h1);
    chk("t3_b1_last", 32'(ifa.io_out_last), 32'h0);
    ifa.io_in_bits[15:8] = 8'h32;
    #4;
    chk("t3_locked_ready", 32'(ifa.io_in_ready), 32'h2);
    tick();
    chk("t3_b2_chosen", 32'(ifa.io_out_chosen), 32'h1);
    chk("t3_b2_bits", 32'(ifa.io_out_bits), 32'h32);
    chk("t3_b2_last", 32'(ifa.io_out_last), 32'h0);
    ifa.io_in_bits[15:8] = 8'h33;
    ifa.io_in_last       = 4'b1111;
    tick();
    chk("t3_b3_chosen", 32'(ifa.io_out_chosen), 32'h1);
    chk("t3_b3_last", 32'(ifa.io_out_last), 32'h1);
    tick();
    chk("t3_next_chosen", 32'(ifa.io_out_chosen), 32'h2);
    chk("t3_next_last", 32'(ifa.io_out_last), 32'h1);
    tick();
    chk("t3_wrap_chosen", 32'(ifa.io_out_chosen), 32'h0);
    chk("t3_wrap_last", 32'(ifa.io_out_last), 32'h1);

    // 4: backpressure holds the output register, then drains in order
    do_reset();
    ifa.io_in_valid  = 4'b1111;
    ifa.io_in_bits   = {8'h43, 8'h42, 8'h41, 8'h40};
    ifa.io_in_last   = 4'b1111;
    ifa.io_out_ready = 1'b0;
    tick();
    chk("t4_load_bits", 32'(ifa.io_out_bits), 32'h40);
    for (int k = 0; k < 3; k++) begin
      chk("t4_stall_ready", 32'(ifa.io_in_ready), 32'h0);
      tick();
      chk("t4_stall_bits", 32'(ifa.io_out_bits), 32'h40);
      chk("t4_stall_valid", 32'(ifa.io_out_valid), 32'h1);
    end
    ifa.io_out_ready = 1'b1;
    #4;
    chk("t4_resume_ready", 32'(ifa.io_in_ready), 32'h2);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("t4_drain_bits", 32'(ifa.io_out_bits), 32'(8'h40 + k % 4));
    end

    // 5: locked ch2 goes idle; ch3 must wait
    do_reset();
    ifa.io_in_valid = 4'b0100;
    ifa.io_in_bits  = {8'h53, 8'h52, 8'h00, 8'h00};
    ifa.io_in_last  = 4'b1000;
    tick();
    chk("t5_lock_chosen", 32'(ifa.io_out_chosen), 32'h2);
    chk("t5_lock_last", 32'(ifa.io_out_last), 32'h0);
    ifa.io_in_valid = 4'b1000;
    #4;
    chk("t5_gap_ready", 32'(ifa.io_in_ready), 32'h0);
    tick();
    chk("t5_gap_valid1", 32'(ifa.io_out_valid), 32'h0);
    chk("t5_gap_ready1", 32'(ifa.io_in_ready), 32'h0);
    tick();
    chk("t5_gap_valid2", 32'(ifa.io_out_valid), 32'h0);
    ifa.io_in_valid = 4'b1100;
    ifa.io_in_bits  = {8'h53, 8'h5A, 8'h00, 8'h00};
    ifa.io_in_last  = 4'b1100;
    #4;
    chk("t5_return_ready", 32'(ifa.io_in_ready), 32'h4);
    tick();
    chk("t5_return_chosen", 32'(ifa.io_out_chosen), 32'h2);
    chk("t5_return_bits", 32'(ifa.io_out_bits), 32'h5A);
    chk("t5_return_last", 32'(ifa.io_out_last), 32'h1);
    tick();
    chk("t5_ch3_chosen", 32'(ifa.io_out_chosen), 32'h3);
    chk("t5_ch3_bits", 32'(ifa.io_out_bits), 32'h53);

    // 6: three-input instance wraps 2 -> 0
    do_reset();
    ifb.io_in_valid = 3'b111;
    ifb.io_in_bits  = {8'h62, 8'h61, 8'h60};
    ifb.io_in_last  = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_chosen", 32'(ifb.io_out_chosen), 32'(k % 3));
      chk("t6_bits", 32'(ifb.io_out_bits), 32'(8'h60 + k % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
